chess_cell_scanner: RTL and testbench

Parametrised successor to the per-square chess transceiver cell. It holds one square's piece and position, emits that piece's attack rays and knight jumps to its neighbours, and forwards sliding rays across an empty square with one registered cycle per hop. It captures first-arrival engine-colour moves landing on the square during a bounded scan window, then drains them one at a time over a valid/ready handshake. One instance per board square; the scan controller drives `start` to all cells together.

---
 rtl/chess_cell_scanner.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_chess_cell_scanner.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_cell_scanner.sv
// -----------------------------------------------------------------------------
// chess_cell_scanner
//
// One board-square cell of the move scanner. It holds the square's piece and
// index, emits that piece's sliding/king/pawn attack rays and knight jumps to
// the neighbouring cells, and forwards rook/bishop rays across an empty square
// (one registered hop per square). During a SETTLE-cycle scan window it
// latches the first engine-colour attack arriving on each ray/knight slot,
// then drains the latched moves one at a time over a valid/ready handshake.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   engine_color    side whose moves are collected (1 = white, 0 = black)
//   load            latch piece_in / pos_in (IDLE only)
//   piece_in        {color, rook, bishop, king, pawn, knight}, 0 = empty
//   pos_in          this square's index
//   start           begin a scan (IDLE only)
//   ray_in          N_DIR words {color, attack, origin} from neighbour d
//   kn_in           N_KN words {color, valid, origin} from knight offset k
//   ray_out         N_DIR words to neighbour d (registered)
//   kn_out          N_KN words to knight offset k (registered)
//   move_valid      move_data holds a captured move
//   move_ready      consumer accepts the presented move
//   move_data       {from, to, capture}
//   busy            high in SCAN or DRAIN
//   done            one-cycle pulse as DRAIN returns to IDLE
// -----------------------------------------------------------------------------
module chess_cell_scanner #(
    parameter int POS_W  = 6,
    parameter int ATK_W  = 4,
    parameter int N_DIR  = 8,
    parameter int N_KN   = 8,
    parameter int SETTLE = 7
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              engine_color,
    input  logic                              load,
    input  logic [5:0]                        piece_in,
    input  logic [POS_W-1:0]                  pos_in,
    input  logic                              start,
    input  logic [N_DIR*(1+ATK_W+POS_W)-1:0]  ray_in,
    input  logic [N_KN*(2+POS_W)-1:0]         kn_in,
    output logic [N_DIR*(1+ATK_W+POS_W)-1:0]  ray_out,
    output logic [N_KN*(2+POS_W)-1:0]         kn_out,
    output logic                              move_valid,
    input  logic                              move_ready,
    output logic [2*POS_W:0]                  move_data,
    output logic                              busy,
    output logic                              done
);

    localparam int RAY_W  = 1 + ATK_W + POS_W;
    localparam int KN_W   = 2 + POS_W;
    localparam int N_SLOT = N_DIR + N_KN;
    localparam int SEL_W  = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
    localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    // attack field bit positions, MSB first {rook, bishop, king, pawn}
    localparam int A_ROOK   = ATK_W - 1;
    localparam int A_BISHOP = ATK_W - 2;
    localparam int A_KING   = ATK_W - 3;
    localparam int A_PAWN   = ATK_W - 4;

    // piece word bit positions
    localparam int P_COLOR  = 5;
    localparam int P_ROOK   = 4;
    localparam int P_BISHOP = 3;
    localparam int P_KING   = 2;
    localparam int P_PAWN   = 1;
    localparam int P_KNIGHT = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [5:0]          piece_q, piece_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [N_SLOT-1:0]   pending_q, pending_d;
    logic [POS_W-1:0]    org_q [N_SLOT];
    logic [N_SLOT-1:0]   cap_q;

    logic [RAY_W-1:0]    ray_out_q [N_DIR];
    logic [RAY_W-1:0]    ray_out_d [N_DIR];
    logic [KN_W-1:0]     kn_out_q  [N_KN];
    logic [KN_W-1:0]     kn_out_d  [N_KN];

    logic [N_SLOT-1:0]   hit;
    logic [POS_W-1:0]    hit_org [N_SLOT];

    logic                occupied;
    logic                enemy;
    logic                occ_ok;
    logic                scan_hold;
    logic                any_pending;
    logic [SEL_W-1:0]    sel_idx;

    assign occupied = |piece_q;
    // an occupied square is only a target when it holds the non-engine side
    assign enemy    = occupied && (piece_q[P_COLOR] != engine_color);
    assign occ_ok   = !occupied || enemy;

    // Outputs are driven only while the scan continues into the next cycle,
    // so the registered words are zero on the first SCAN cycle and in DRAIN.
    assign scan_hold = (state_q == S_SCAN) && (state_d == S_SCAN);

    // -------------------------------------------------------------------------
    // Ray emission and forwarding, one generate branch per output direction.
    // Output d forwards what arrives from the opposite neighbour; opposite is
    // d^1 for the orthogonal pairs and d^3 for the diagonal pairs.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_DIR; gi++) begin : g_dir
            localparam int SRC = (gi < 4) ? (gi ^ 1) : (gi ^ 3);
            localparam bit UP_DIAG = (gi == 4) || (gi == 5);
            localparam bit DN_DIAG = (gi == 6) || (gi == 7);

            logic [RAY_W-1:0] src_word;
            logic [ATK_W-1:0] own_atk;
            logic [ATK_W-1:0] fwd_atk;

            assign src_word = ray_in[SRC*RAY_W +: RAY_W];

            if (gi < 4) begin : g_orth
                always_comb begin
                    own_atk          = '0;
                    own_atk[A_ROOK]  = piece_q[P_ROOK];
                    own_atk[A_KING]  = piece_q[P_KING];
                    fwd_atk          = '0;
                    fwd_atk[A_ROOK]  = src_word[POS_W + A_ROOK];
                end
            end else begin : g_diag
                always_comb begin
                    own_atk           = '0;
                    own_atk[A_BISHOP] = piece_q[P_BISHOP];
                    own_atk[A_KING]   = piece_q[P_KING];
                    // pawns attack forward only: white up, black down
                    own_atk[A_PAWN]   = piece_q[P_PAWN] &
                                        (piece_q[P_COLOR] ? UP_DIAG : DN_DIAG);
                    fwd_atk           = '0;
                    fwd_atk[A_BISHOP] = src_word[POS_W + A_BISHOP];
                end
            end

            always_comb begin
                ray_out_d[gi] = '0;
                if (scan_hold) begin
                    if (occupied) begin
                        if (|own_atk)
                            ray_out_d[gi] = {piece_q[P_COLOR], own_atk, pos_q};
                    end else if (|fwd_atk) begin
                        ray_out_d[gi] = {src_word[RAY_W-1], fwd_atk,
                                         src_word[POS_W-1:0]};
                    end
                end
            end

            assign ray_out[gi*RAY_W +: RAY_W] = ray_out_q[gi];
        end

        for (gi = 0; gi < N_KN; gi++) begin : g_kn
            assign kn_out_d[gi] = (scan_hold && piece_q[P_KNIGHT]) ?
                                  {piece_q[P_COLOR], 1'b1, pos_q} : '0;
            assign kn_out[gi*KN_W +: KN_W] = kn_out_q[gi];
        end

        // ---------------------------------------------------------------------
        // Capture qualification per slot: rays occupy slots 0..N_DIR-1,
        // knights follow.
        // ---------------------------------------------------------------------
        for (gi = 0; gi < N_DIR; gi++) begin : g_ray_cap
            logic [RAY_W-1:0] w;
            logic [ATK_W-1:0] atk;
            logic             pawn_only;

            assign w         = ray_in[gi*RAY_W +: RAY_W];
            assign atk       = w[POS_W +: ATK_W];
            assign pawn_only = (atk == ATK_W'(1));
            // a pawn only attacks diagonally onto an enemy piece
            assign hit[gi]   = (w[RAY_W-1] == engine_color) && (|atk) &&
                               occ_ok && (!pawn_only || enemy);
            assign hit_org[gi] = w[POS_W-1:0];
        end

        for (gi = 0; gi < N_KN; gi++) begin : g_kn_cap
            logic [KN_W-1:0] w;

            assign w = kn_in[gi*KN_W +: KN_W];
            assign hit[N_DIR+gi]     = w[KN_W-2] && (w[KN_W-1] == engine_color) &&
                                       occ_ok;
            assign hit_org[N_DIR+gi] = w[POS_W-1:0];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Drain selection: lowest pending slot wins.
    // -------------------------------------------------------------------------
    assign any_pending = |pending_q;

    always_comb begin
        sel_idx = '0;
        for (int i = N_SLOT - 1; i >= 0; i--) begin
            if (pending_q[i])
                sel_idx = SEL_W'(i);
        end
    end

    assign busy       = (state_q == S_SCAN) || (state_q == S_DRAIN);
    assign move_valid = (state_q == S_DRAIN) && any_pending;
    assign done       = (state_q == S_DRAIN) && !any_pending;
    assign move_data  = move_valid ? {org_q[sel_idx], pos_q, cap_q[sel_idx]}
                                   : '0;

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        piece_d   = piece_q;
        pos_d     = pos_q;
        pending_d = pending_q;

        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    piece_d = piece_in;
                    pos_d   = pos_in;
                end
                if (start) begin
                    state_d   = S_SCAN;
                    cnt_d     = '0;
                    pending_d = '0;
                end
            end

            S_SCAN: begin
                // pending bits are sticky, so only the first arrival counts
                pending_d = pending_q | hit;
                if (cnt_q == CNT_W'(SETTLE - 1))
                    state_d = S_DRAIN;
                else
                    cnt_d = cnt_q + 1'b1;
            end

            S_DRAIN: begin
                if (!any_pending)
                    state_d = S_IDLE;
                else if (move_ready)
                    pending_d[sel_idx] = 1'b0;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            piece_q   <= '0;
            pos_q     <= '0;
            pending_q <= '0;
            for (int i = 0; i < N_DIR; i++)
                ray_out_q[i] <= '0;
            for (int i = 0; i < N_KN; i++)
                kn_out_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            piece_q   <= piece_d;
            pos_q     <= pos_d;
            pending_q <= pending_d;
            for (int i = 0; i < N_DIR; i++)
                ray_out_q[i] <= ray_out_d[i];
            for (int i = 0; i < N_KN; i++)
                kn_out_q[i] <= kn_out_d[i];
        end
    end

    // Payload is only read under a pending bit, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SLOT; i++) begin
            if ((state_q == S_SCAN) && hit[i] && !pending_q[i]) begin
                org_q[i] <= hit_org[i];
                cap_q[i] <= occupied;
            end
        end
    end

endmodule

// File: tb/tb_chess_cell_scanner.sv
module tb_chess_cell_scanner;

    localparam int POS_W  = 6;
    localparam int ATK_W  = 4;
    localparam int N_DIR  = 8;
    localparam int N_KN   = 8;
    localparam int SETTLE = 7;
    localparam int RAY_W  = 1 + ATK_W + POS_W;
    localparam int KN_W   = 2 + POS_W;
    localparam int MOVE_W = 2 * POS_W + 1;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     engine_color = 1'b0;
    logic                     load = 1'b0;
    logic [5:0]               piece_in = '0;
    logic [POS_W-1:0]         pos_in = '0;
    logic                     start = 1'b0;
    logic [N_DIR*RAY_W-1:0]   ray_in = '0;
    logic [N_KN*KN_W-1:0]     kn_in = '0;
    logic [N_DIR*RAY_W-1:0]   ray_out;
    logic [N_KN*KN_W-1:0]     kn_out;
    logic                     move_valid;
    logic                     move_ready = 1'b0;
    logic [MOVE_W-1:0]        move_data;
    logic                     busy;
    logic                     done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [MOVE_W-1:0] exp_q[$];

    chess_cell_scanner #(
        .POS_W (POS_W),
        .ATK_W (ATK_W),
        .N_DIR (N_DIR),
        .N_KN  (N_KN),
        .SETTLE(SETTLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .engine_color(engine_color),
        .load        (load),
        .piece_in    (piece_in),
        .pos_in      (pos_in),
        .start       (start),
        .ray_in      (ray_in),
        .kn_in       (kn_in),
        .ray_out     (ray_out),
        .kn_out      (kn_out),
        .move_valid  (move_valid),
        .move_ready  (move_ready),
        .move_data   (move_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RAY_W-1:0] ray_w(input logic c,
                                               input logic [ATK_W-1:0] a,
                                               input logic [POS_W-1:0] o);
        return {c, a, o};
    endfunction

    function automatic logic [KN_W-1:0] kn_w(input logic c, input logic v,
                                             input logic [POS_W-1:0] o);
        return {c, v, o};
    endfunction

    function automatic logic [MOVE_W-1:0] mv(input logic [POS_W-1:0] f,
                                             input logic [POS_W-1:0] t,
                                             input logic c);
        return {f, t, c};
    endfunction

    function automatic logic [RAY_W-1:0] ray_out_w(input int d);
        return ray_out[d*RAY_W +: RAY_W];
    endfunction

    function automatic logic [KN_W-1:0] kn_out_w(input int k);
        return kn_out[k*KN_W +: KN_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_ray(input int d, input logic [RAY_W-1:0] w);
        ray_in[d*RAY_W +: RAY_W] = w;
    endtask

    task automatic set_kn(input int k, input logic [KN_W-1:0] w);
        kn_in[k*KN_W +: KN_W] = w;
    endtask

    task automatic clear_inputs();
        ray_in = '0;
        kn_in  = '0;
    endtask

    task automatic load_piece(input logic [5:0] p, input logic [POS_W-1:0] pos);
        load     = 1'b1;
        piece_in = p;
        pos_in   = pos;
        tick();
        load     = 1'b0;
    endtask

    // leaves the bench one cycle after the start edge (first SCAN cycle, cyc=1)
    task automatic do_start();
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    // Runs until done, stalling the first presented move for 'hold' cycles.
    // Every accepted move is matched against the scoreboard head.
    task automatic drain(input string tag, input int hold);
        int m;
        int hold_left;
        int done_cyc;
        logic [MOVE_W-1:0] e;
        m         = exp_q.size();
        hold_left = hold;
        done_cyc  = -1;
        for (int n = 0; n < 200; n++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (move_valid && hold_left > 0) begin
                move_ready = 1'b0;
                if (exp_q.size() > 0)
                    check_val({tag, "_hold_data"}, 128'(move_data), 128'(exp_q[0]));
                hold_left--;
            end else begin
                move_ready = 1'b1;
                if (move_valid) begin
                    if (exp_q.size() == 0) begin
                        check_val({tag, "_sb_underflow"}, 128'(0), 128'(1));
                    end else begin
                        e = exp_q.pop_front();
                        $display("%s move from=%0d to=%0d cap=%0b", tag,
                                 move_data[MOVE_W-1 -: POS_W],
                                 move_data[POS_W:1], move_data[0]);
                        check_val({tag, "_move"}, 128'(move_data), 128'(e));
                    end
                end
            end
            tick();
        end
        if (done_cyc < 0)
            check_val({tag, "_drain_timeout"}, 128'(0), 128'(1));
        else
            check_val({tag, "_done_cycle"}, 128'(done_cyc),
                      128'(SETTLE + 1 + m + hold));
        check_val({tag, "_sb_left"}, 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        move_ready = 1'b0;
        tick();
        check_val({tag, "_busy_after"}, 128'(busy), 128'(0));
        check_val({tag, "_done_pulse"}, 128'(done), 128'(0));
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_val("rst_ray_out",    128'(ray_out),    128'(0));
        check_val("rst_kn_out",     128'(kn_out),     128'(0));
        check_val("rst_move_valid", 128'(move_valid), 128'(0));
        check_val("rst_move_data",  128'(move_data),  128'(0));
        check_val("rst_busy",       128'(busy),       128'(0));
        check_val("rst_done",       128'(done),       128'(0));

        // ---------------- A: empty square forwards a rook ray ----------------
        engine_color = 1'b0;
        clear_inputs();
        load_piece(6'b000000, 6'd28);
        set_ray(1, ray_w(1'b0, 4'b1000, 6'd20));
        exp_q.push_back(mv(6'd20, 6'd28, 1'b0));
        do_start();
        check_val("A_busy", 128'(busy), 128'(1));
        tick();
        check_val("A_fwd_U", 128'(ray_out_w(0)), 128'(ray_w(1'b0, 4'b1000, 6'd20)));
        check_val("A_fwd_D", 128'(ray_out_w(1)), 128'(0));
        drain("A", 0);

        // ---------------- B: own black queen, nothing captured ----------------
        clear_inputs();
        load_piece(6'b011000, 6'd28);
        set_ray(2, ray_w(1'b0, 4'b1100, 6'd29));
        set_kn(1, kn_w(1'b0, 1'b1, 6'd43));
        do_start();
        check_val("B_first_scan_quiet", 128'(ray_out_w(0)), 128'(0));
        tick();
        check_val("B_emit_U",  128'(ray_out_w(0)), 128'(ray_w(1'b0, 4'b1000, 6'd28)));
        check_val("B_emit_UL", 128'(ray_out_w(4)), 128'(ray_w(1'b0, 4'b0100, 6'd28)));
        check_val("B_emit_R",  128'(ray_out_w(3)), 128'(ray_w(1'b0, 4'b1000, 6'd28)));
        check_val("B_kn_out",  128'(kn_out), 128'(0));
        // load while busy must not disturb the held piece
        load     = 1'b1;
        piece_in = 6'b000000;
        pos_in   = 6'd5;
        tick();
        load = 1'b0;
        check_val("B_load_ignored", 128'(ray_out_w(0)), 128'(ray_w(1'b0, 4'b1000, 6'd28)));
        drain("B", 0);

        // ---------------- C: white rook, pawn capture then knight capture ----
        clear_inputs();
        load_piece(6'b110000, 6'd28);
        set_ray(6, ray_w(1'b0, 4'b0001, 6'd19));
        set_kn(1, kn_w(1'b0, 1'b1, 6'd43));
        exp_q.push_back(mv(6'd19, 6'd28, 1'b1));
        exp_q.push_back(mv(6'd43, 6'd28, 1'b1));
        do_start();
        tick();
        check_val("C_emit_U",  128'(ray_out_w(0)), 128'(ray_w(1'b1, 4'b1000, 6'd28)));
        check_val("C_emit_UL", 128'(ray_out_w(4)), 128'(0));
        drain("C", 0);

        // ---------------- E: same setup, consumer stalls 5 cycles ----------------
        exp_q.push_back(mv(6'd19, 6'd28, 1'b1));
        exp_q.push_back(mv(6'd43, 6'd28, 1'b1));
        do_start();
        drain("E", 5);

        // ---------------- D: king ray, pawn on empty, wrong colour ----------------
        clear_inputs();
        load_piece(6'b000000, 6'd28);
        set_ray(0, ray_w(1'b0, 4'b0010, 6'd36));
        set_ray(7, ray_w(1'b0, 4'b0001, 6'd21));
        set_ray(3, ray_w(1'b1, 4'b1000, 6'd30));
        exp_q.push_back(mv(6'd36, 6'd28, 1'b0));
        do_start();
        tick();
        check_val("D_king_stops",  128'(ray_out_w(1)), 128'(0));
        check_val("D_pawn_stops",  128'(ray_out_w(4)), 128'(0));
        check_val("D_fwd_L",       128'(ray_out_w(2)), 128'(ray_w(1'b1, 4'b1000, 6'd30)));
        // a later arrival on the already-latched slot is ignored
        set_ray(0, ray_w(1'b0, 4'b0010, 6'd37));
        drain("D", 0);

        // ---------------- F: reset in the middle of a scan ----------------
        clear_inputs();
        load_piece(6'b100001, 6'd28);
        set_ray(3, ray_w(1'b0, 4'b1000, 6'd30));
        do_start();
        tick();
        check_val("F_kn_emit", 128'(kn_out_w(0)), 128'(kn_w(1'b1, 1'b1, 6'd28)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("F_rst_ray_out",    128'(ray_out),    128'(0));
        check_val("F_rst_kn_out",     128'(kn_out),     128'(0));
        check_val("F_rst_busy",       128'(busy),       128'(0));
        check_val("F_rst_move_valid", 128'(move_valid), 128'(0));
        check_val("F_rst_done",       128'(done),       128'(0));
        clear_inputs();
        load_piece(6'b100001, 6'd28);
        do_start();
        tick();
        check_val("F_rescan_kn", 128'(kn_out_w(3)), 128'(kn_w(1'b1, 1'b1, 6'd28)));
        drain("F", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
